// File: rtl/board_scan_rx.sv
// Host-side receiver for the tic-tac-toe chip's scanned board stream.
// Recovers frame alignment, keeps a shadow board and reports new moves over valid/ready.
module board_scan_rx #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  scan_xoro,
  input  logic [1:0]  scan_row,
  input  logic [1:0]  scan_col,
  input  logic [1:0]  scan_win,
  output logic [17:0] board,
  output logic        board_valid,
  output logic        frame_done,
  output logic        sync_err,
  output logic        locked,
  output logic [1:0]  win_out,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_row,
  output logic [1:0]  evt_col,
  output logic [1:0]  evt_xoro,
  output logic        base_err
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  localparam logic [3:0] LOCK_THR = 4'(LOCK_FRAMES);

  state_t      r_state, w_stateNext;
  logic [3:0]  r_expect, w_expectNext;
  logic [15:0] r_staging;
  logic [3:0]  r_goodCnt, w_cntNext;
  logic [8:0]  r_pending, w_pendingNext;

  logic [3:0]  w_idx;
  logic        w_parseErr, w_clean0;
  logic        w_stageWr, w_commit, w_syncErr;
  logic [17:0] w_newBoard;
  logic [8:0]  w_newBits, w_ackBits;
  logic        w_baseErr;
  logic [3:0]  w_lowIdx;
  logic [1:0]  w_xoroSel;

  assign w_idx      = {2'b00, scan_row} * 4'd3 + {2'b00, scan_col};
  assign w_parseErr = (scan_row == 2'd3) || (scan_col == 2'd3) || (scan_xoro == 2'b11);
  assign w_clean0   = !w_parseErr && (w_idx == 4'd0);
  // The idx-8 sample is never staged; it goes straight into the committed board.
  assign w_newBoard = {scan_xoro, r_staging};

  always_comb begin
    w_stateNext  = r_state;
    w_expectNext = r_expect;
    w_stageWr    = 1'b0;
    w_commit     = 1'b0;
    w_syncErr    = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_clean0) begin
          w_stateNext  = CAPTURE;
          w_expectNext = 4'd1;
          w_stageWr    = 1'b1;
        end
      end
      CAPTURE: begin
        if (!w_parseErr && (w_idx == r_expect)) begin
          w_stageWr = 1'b1;
          if (w_idx == 4'd8) begin
            w_commit     = 1'b1;
            w_expectNext = 4'd0;
          end else begin
            w_expectNext = r_expect + 4'd1;
          end
        end else begin
          w_syncErr = 1'b1;
          if (w_clean0) begin
            w_expectNext = 4'd1;
            w_stageWr    = 1'b1;
          end else begin
            w_stateNext  = HUNT;
            w_expectNext = 4'd0;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_newBits = '0;
    w_baseErr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (board[2*k +: 2] == 2'b00 && w_newBoard[2*k +: 2] != 2'b00)
        w_newBits[k] = 1'b1;
      if (board[2*k +: 2] != 2'b00 && w_newBoard[2*k +: 2] != board[2*k +: 2])
        w_baseErr = 1'b1;
    end
  end

  always_comb begin
    w_lowIdx = '0;
    for (int k = 8; k >= 0; k--)
      if (r_pending[k]) w_lowIdx = 4'(k);
  end

  assign evt_valid = |r_pending;

  always_comb begin
    evt_row   = '0;
    evt_col   = '0;
    w_xoroSel = '0;
    w_ackBits = '0;
    for (int k = 0; k < 9; k++) begin
      if (w_lowIdx == 4'(k)) begin
        evt_row      = 2'(k / 3);
        evt_col      = 2'(k % 3);
        w_xoroSel    = board[2*k +: 2];
        w_ackBits[k] = evt_valid && evt_ready;
      end
    end
  end

  assign evt_xoro = evt_valid ? w_xoroSel : 2'b00;

  // A base error discards all pending moves; the new board simply becomes the baseline.
  always_comb begin
    w_pendingNext = r_pending & ~w_ackBits;
    if (w_commit && board_valid)
      w_pendingNext = w_baseErr ? 9'd0 : (w_pendingNext | w_newBits);
    w_cntNext = r_goodCnt;
    if (w_syncErr)
      w_cntNext = 4'd0;
    else if (w_commit && r_goodCnt != 4'd15)
      w_cntNext = r_goodCnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_expect    <= '0;
      r_staging   <= '0;
      r_goodCnt   <= '0;
      r_pending   <= '0;
      board       <= '0;
      board_valid <= 1'b0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
      win_out     <= '0;
      base_err    <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_expect   <= w_expectNext;
      r_goodCnt  <= w_cntNext;
      r_pending  <= w_pendingNext;
      frame_done <= w_commit;
      sync_err   <= w_syncErr;
      locked     <= (w_cntNext >= LOCK_THR);
      base_err   <= w_commit && board_valid && w_baseErr;
      for (int k = 0; k < 8; k++)
        if (w_stageWr && w_idx == 4'(k)) r_staging[2*k +: 2] <= scan_xoro;
      if (w_commit) begin
        board       <= w_newBoard;
        win_out     <= scan_win;
        board_valid <= 1'b1;
      end
    end
  end

endmodule
